// File: rtl/dw_window_seq.sv
// dw_window_seq -- depthwise input-buffer window sequencer.
//
// Walks a KSIZE x KSIZE window over one block for POY parallel output rows.
// For every output column the address side emits KSIZE phases, each made of
// one TRAN cycle (buffer read) and KSIZE-1 SHIFT cycles, so one column takes
// KSIZE*KSIZE cycles. The reg-array command, dwpe_ena and fifo_read are
// delayed RD_LAT cycles through a delay line so they line up with the
// buffer read data.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   start           block start pulse, ignored while busy
//   cfg_stride      column stride (0 and 3 act as 1), latched at start
//   cfg_ncol        output columns in the block (0 => done next cycle)
//   hold            downstream stall, freezes the whole sequencer
//   rd_en/rd_rpsel/rd_bank/rd_row/rd_col   input-buffer read request
//   reg_array_cmd   per-lane command, lane i at [2i+1:2i]
//   fifo_read       pulse one cycle ahead of each IF command
//   dwpe_ena        compute enable, aligned with reg_array_cmd
//   busy, done      block handshake
module dw_window_seq #(
    parameter int KSIZE  = 3,
    parameter int POY    = 3,
    parameter int NBANK  = 3,
    parameter int ROW_W  = 4,
    parameter int COL_W  = 8,
    parameter int RD_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               cfg_stride,
    input  logic [COL_W-1:0]         cfg_ncol,
    input  logic                     hold,
    output logic                     rd_en,
    output logic [1:0]               rd_rpsel,
    output logic [$clog2(NBANK)-1:0] rd_bank,
    output logic [ROW_W-1:0]         rd_row,
    output logic [COL_W-1:0]         rd_col,
    output logic [2*POY-1:0]         reg_array_cmd,
    output logic                     fifo_read,
    output logic                     dwpe_ena,
    output logic                     busy,
    output logic                     done
);
    localparam int PW = $clog2(KSIZE);
    localparam int FW = $clog2(RD_LAT + 1);
    localparam int BW = $clog2(NBANK);
    localparam int CW = 2 * POY;

    localparam logic [PW-1:0]    P_LAST    = PW'(KSIZE - 1);
    localparam logic [PW-1:0]    S_LAST    = PW'(KSIZE - 2);
    localparam logic [FW-1:0]    F_LAST    = FW'(RD_LAT - 1);
    localparam logic [BW-1:0]    B_LAST    = BW'(NBANK - 1);
    // First banked read of a column is row index POY; split at elaboration.
    localparam logic [BW-1:0]    BASE_BANK = BW'(POY % NBANK);
    localparam logic [ROW_W-1:0] BASE_ROW  = ROW_W'(POY / NBANK);

    localparam logic [1:0] RP_RR = 2'b00;
    localparam logic [1:0] RP_BR = 2'b01;
    localparam logic [1:0] RP_NE = 2'b11;

    localparam logic [CW-1:0] CMD_IB = {POY{2'b00}};
    localparam logic [CW-1:0] CMD_SF = {POY{2'b01}};
    localparam logic [CW-1:0] CMD_NE = {POY{2'b11}};
    // Lanes 0..POY-2 take the shifted-in fifo row, top lane loads the new buffer row.
    localparam logic [CW-1:0] CMD_IF = {2'b00, {(POY-1){2'b10}}};

    typedef enum logic [1:0] {S_IDLE, S_TRAN, S_SHIFT, S_FLUSH} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     ph, ph_n, sh, sh_n;
    logic [FW-1:0]     fc, fc_n;
    logic [COL_W-1:0]  col, col_n, left, left_n, ncol_q, l_ncol;
    logic [BW-1:0]     bank, bank_n;
    logic [ROW_W-1:0]  row, row_n;
    logic [1:0]        stride_q, stride_n, l_stride, stride_eff;
    logic              pend;  // start seen under hold, launch once hold drops
    logic              busy_n, done_n;
    logic              rd_en_n, ena_n, if_n;
    logic [1:0]        rps_n;
    logic [BW-1:0]     rbank_n;
    logic [ROW_W-1:0]  rrow_n;
    logic [COL_W-1:0]  rcol_n;
    logic [CW-1:0]     cmd_n;

    // Command delay line: stage 0 belongs to the address cycle on the outputs now.
    logic [CW-1:0]     pcmd [RD_LAT];
    logic              pena [RD_LAT];
    logic              pif  [RD_LAT];
    logic              fifo_src;

    assign stride_eff = (cfg_stride == 2'd2) ? 2'd2 : 2'd1;

    if (RD_LAT == 1) begin : g_fifo_direct
        assign fifo_src = if_n;
    end else begin : g_fifo_pipe
        assign fifo_src = pif[RD_LAT-2];
    end

    // Computes the next address cycle; registered straight onto the outputs.
    always_comb begin
        state_n  = state;
        ph_n     = ph;
        sh_n     = sh;
        fc_n     = fc;
        col_n    = col;
        left_n   = left;
        bank_n   = bank;
        row_n    = row;
        stride_n = stride_q;
        busy_n   = busy;
        done_n   = 1'b0;
        rd_en_n  = 1'b0;
        rps_n    = RP_NE;
        rbank_n  = rd_bank;
        rrow_n   = rd_row;
        rcol_n   = rd_col;
        cmd_n    = CMD_NE;
        ena_n    = 1'b0;
        if_n     = 1'b0;
        l_stride = pend ? stride_q : stride_eff;
        l_ncol   = pend ? ncol_q : cfg_ncol;
        case (state)
            S_IDLE: if (start || pend) begin
                if (l_ncol == '0) begin
                    done_n = 1'b1;
                    busy_n = 1'b0;
                end else begin
                    state_n  = S_TRAN;
                    ph_n     = '0;
                    col_n    = '0;
                    left_n   = l_ncol;
                    stride_n = l_stride;
                    bank_n   = BASE_BANK;
                    row_n    = BASE_ROW;
                    busy_n   = 1'b1;
                    rd_en_n  = 1'b1;
                    rps_n    = RP_RR;
                    rrow_n   = '0;
                    rcol_n   = '0;
                    cmd_n    = CMD_IB;
                    ena_n    = 1'b1;
                end
            end
            S_TRAN: begin
                state_n = S_SHIFT;
                sh_n    = '0;
                cmd_n   = CMD_SF;
                ena_n   = 1'b1;
            end
            S_SHIFT: begin
                if (sh != S_LAST) begin
                    sh_n  = sh + PW'(1);
                    cmd_n = CMD_SF;
                    ena_n = 1'b1;
                end else if (ph != P_LAST) begin
                    // Banked read of row index POY-1+ph+1 from the wrap counter.
                    state_n = S_TRAN;
                    ph_n    = ph + PW'(1);
                    rd_en_n = 1'b1;
                    rps_n   = RP_BR;
                    rbank_n = bank;
                    rrow_n  = row;
                    rcol_n  = col;
                    cmd_n   = CMD_IF;
                    ena_n   = 1'b1;
                    if_n    = 1'b1;
                    if (bank == B_LAST) begin
                        bank_n = '0;
                        row_n  = row + ROW_W'(1);
                    end else begin
                        bank_n = bank + BW'(1);
                    end
                end else if (left != COL_W'(1)) begin
                    // Column advance folded into the last SHIFT of the column.
                    state_n = S_TRAN;
                    ph_n    = '0;
                    col_n   = col + COL_W'(stride_q);
                    left_n  = left - COL_W'(1);
                    bank_n  = BASE_BANK;
                    row_n   = BASE_ROW;
                    rd_en_n = 1'b1;
                    rps_n   = RP_RR;
                    rrow_n  = '0;
                    rcol_n  = col + COL_W'(stride_q);
                    cmd_n   = CMD_IB;
                    ena_n   = 1'b1;
                end else begin
                    state_n = S_FLUSH;
                    fc_n    = '0;
                end
            end
            S_FLUSH: begin
                if (fc == F_LAST) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    fc_n = fc + FW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            ph            <= '0;
            sh            <= '0;
            fc            <= '0;
            col           <= '0;
            left          <= '0;
            ncol_q        <= '0;
            bank          <= '0;
            row           <= '0;
            stride_q      <= 2'd1;
            pend          <= 1'b0;
            rd_en         <= 1'b0;
            rd_rpsel      <= RP_NE;
            rd_bank       <= '0;
            rd_row        <= '0;
            rd_col        <= '0;
            reg_array_cmd <= CMD_NE;
            fifo_read     <= 1'b0;
            dwpe_ena      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pcmd[i] <= CMD_NE;
                pena[i] <= 1'b0;
                pif[i]  <= 1'b0;
            end
        end else if (hold) begin
            // Everything frozen; only the visible strobes go quiet.
            rd_en         <= 1'b0;
            rd_rpsel      <= RP_NE;
            reg_array_cmd <= CMD_NE;
            fifo_read     <= 1'b0;
            dwpe_ena      <= 1'b0;
            done          <= 1'b0;
            if (state == S_IDLE && start && !pend) begin
                pend     <= 1'b1;
                busy     <= 1'b1;
                stride_q <= stride_eff;
                ncol_q   <= cfg_ncol;
            end
        end else begin
            state         <= state_n;
            ph            <= ph_n;
            sh            <= sh_n;
            fc            <= fc_n;
            col           <= col_n;
            left          <= left_n;
            bank          <= bank_n;
            row           <= row_n;
            stride_q      <= stride_n;
            pend          <= 1'b0;
            rd_en         <= rd_en_n;
            rd_rpsel      <= rps_n;
            rd_bank       <= rbank_n;
            rd_row        <= rrow_n;
            rd_col        <= rcol_n;
            busy          <= busy_n;
            done          <= done_n;
            pcmd[0]       <= cmd_n;
            pena[0]       <= ena_n;
            pif[0]        <= if_n;
            for (int i = 1; i < RD_LAT; i++) begin
                pcmd[i] <= pcmd[i-1];
                pena[i] <= pena[i-1];
                pif[i]  <= pif[i-1];
            end
            reg_array_cmd <= pcmd[RD_LAT-1];
            dwpe_ena      <= pena[RD_LAT-1];
            fifo_read     <= fifo_src;
        end
    end
endmodule

// File: tb/tb_dw_window_seq.sv
// Self-checking bench for dw_window_seq: directed and randomized blocks checked
// against a cycle/sequence model computed from the window-walk rules.
module tb_dw_window_seq;
    localparam int KSIZE  = 3;
    localparam int POY    = 3;
    localparam int NBANK  = 3;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 8;
    localparam int RD_LAT = 3;
    localparam int CW     = 2 * POY;
    localparam int BW     = $clog2(NBANK);

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              hold = 1'b0;
    logic [1:0]        cfg_stride = 2'd0;
    logic [COL_W-1:0]  cfg_ncol = '0;
    logic              rd_en, fifo_read, dwpe_ena, busy, done;
    logic [1:0]        rd_rpsel;
    logic [BW-1:0]     rd_bank;
    logic [ROW_W-1:0]  rd_row;
    logic [COL_W-1:0]  rd_col;
    logic [CW-1:0]     reg_array_cmd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dw_window_seq #(.KSIZE(KSIZE), .POY(POY), .NBANK(NBANK), .ROW_W(ROW_W),
                    .COL_W(COL_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_stride(cfg_stride),
        .cfg_ncol(cfg_ncol), .hold(hold), .rd_en(rd_en), .rd_rpsel(rd_rpsel),
        .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
        .reg_array_cmd(reg_array_cmd), .fifo_read(fifo_read), .dwpe_ena(dwpe_ena),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // kind 0: all IB, 1: all SF, 2: lanes below the top IF, top lane IB
    function automatic logic [CW-1:0] exp_cmd(input int kind);
        logic [CW-1:0] w;
        w = '0;
        for (int l = 0; l < POY; l++)
            w[2*l +: 2] = (kind == 1) ? 2'b01 : ((kind == 2 && l < POY-1) ? 2'b10 : 2'b00);
        return w;
    endfunction

    function automatic logic has_if(input logic [CW-1:0] w);
        logic r;
        r = 1'b0;
        for (int l = 0; l < POY; l++)
            if (w[2*l +: 2] == 2'b10) r = 1'b1;
        return r;
    endfunction

    function automatic logic [CW-1:0] all_ne();
        return {POY{2'b11}};
    endfunction

    // Called right after a posedge (+#1). Pre_hold: hold cycles starting with the
    // start edge. Mid hold: hold asserted for edges hold_at..hold_at+hold_len-1.
    task automatic run_block(input string nm, input int ncol, input int scfg, input int pre_hold,
                             input int hold_at, input int hold_len, input int restart_at);
        int s, t, dn, km, idx, done_k, first_cmd_k, nena, k;
        int exp_k[$], exp_ps[$], exp_a[$], exp_b[$];
        int got_k[$], got_ps[$], got_a[$], got_b[$];
        int fifo_k[$], if_k[$];
        logic [CW-1:0] exp_c[$], got_c[$];

        s = (scfg == 2) ? 2 : 1;
        t = ncol * KSIZE * KSIZE;
        dn = (ncol == 0) ? 1 + pre_hold : t + RD_LAT + 1 + pre_hold + hold_len;
        for (int c = 0; c < ncol; c++) begin
            for (int p = 0; p < KSIZE; p++) begin
                km = 1 + pre_hold + (c * KSIZE + p) * KSIZE;
                if (hold_len > 0 && km > hold_at) km += hold_len;
                exp_k.push_back(km);
                if (p == 0) begin
                    exp_ps.push_back(0);
                    exp_a.push_back(0);
                    exp_b.push_back((c * s) % (1 << COL_W));
                    exp_c.push_back(exp_cmd(0));
                end else begin
                    idx = POY - 1 + p;
                    exp_ps.push_back(1);
                    exp_a.push_back(idx % NBANK);
                    exp_b.push_back(idx / NBANK);
                    exp_c.push_back(exp_cmd(2));
                end
                for (int j = 1; j < KSIZE; j++) exp_c.push_back(exp_cmd(1));
            end
        end

        cfg_ncol   = COL_W'(ncol);
        cfg_stride = 2'(scfg);
        start      = 1'b1;
        hold       = (pre_hold > 0);
        @(posedge clk); #1;
        start = 1'b0;
        done_k = -1;
        first_cmd_k = -1;
        nena = 0;
        for (k = 1; k <= dn + 20; k++) begin
            if (rd_en) begin
                got_k.push_back(k);
                got_ps.push_back(int'(rd_rpsel));
                got_a.push_back(rd_rpsel == 2'b00 ? int'(rd_row) : int'(rd_bank));
                got_b.push_back(rd_rpsel == 2'b00 ? int'(rd_col) : int'(rd_row));
            end
            if (reg_array_cmd != all_ne()) begin
                got_c.push_back(reg_array_cmd);
                if (first_cmd_k < 0) first_cmd_k = k;
            end
            if (dwpe_ena) nena++;
            if (fifo_read) fifo_k.push_back(k);
            if (has_if(reg_array_cmd)) if_k.push_back(k);
            if (hold_len > 0 && k > hold_at && k <= hold_at + hold_len)
                chk({nm, ":hold_idle"}, 32'({rd_en, dwpe_ena, fifo_read, reg_array_cmd}),
                    32'({1'b0, 1'b0, 1'b0, all_ne()}));
            if (k == 1 && ncol > 0) chk({nm, ":busy_first"}, 32'(busy), 32'd1);
            if (done) begin
                done_k = k;
                chk({nm, ":busy_at_done"}, 32'(busy), 32'd0);
                break;
            end
            if (k == dn - 1 && ncol > 0) chk({nm, ":busy_before_done"}, 32'(busy), 32'd1);
            hold  = (k < pre_hold) || (hold_len > 0 && k >= hold_at && k < hold_at + hold_len);
            start = (k == restart_at);
            @(posedge clk); #1;
        end
        start = 1'b0;
        hold  = 1'b0;
        chk({nm, ":done_cycle"}, done_k, dn);
        @(posedge clk); #1;
        chk({nm, ":done_pulse"}, 32'({done, busy}), 32'd0);

        chk({nm, ":n_reads"}, got_k.size(), exp_k.size());
        for (int i = 0; i < exp_k.size() && i < got_k.size(); i++) begin
            chk($sformatf("%s:rd%0d_cycle", nm, i), got_k[i], exp_k[i]);
            chk($sformatf("%s:rd%0d_rpsel", nm, i), got_ps[i], exp_ps[i]);
            chk($sformatf("%s:rd%0d_a", nm, i), got_a[i], exp_a[i]);
            chk($sformatf("%s:rd%0d_b", nm, i), got_b[i], exp_b[i]);
        end
        chk({nm, ":n_cmds"}, got_c.size(), exp_c.size());
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++)
            chk($sformatf("%s:cmd%0d", nm, i), 32'(got_c[i]), 32'(exp_c[i]));
        chk({nm, ":dwpe_count"}, nena, t);
        if (ncol > 0) chk({nm, ":first_cmd"}, first_cmd_k, 1 + pre_hold + RD_LAT);
        if (hold_len == 0) begin
            chk({nm, ":n_fifo"}, fifo_k.size(), if_k.size());
            for (int i = 0; i < fifo_k.size() && i < if_k.size(); i++)
                chk($sformatf("%s:fifo%0d", nm, i), fifo_k[i], if_k[i] - 1);
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20;
        chk("reset_strobes", 32'({rd_en, fifo_read, dwpe_ena, busy, done}), 32'd0);
        chk("reset_rpsel", 32'(rd_rpsel), 32'd3);
        chk("reset_addr", 32'({rd_bank, rd_row, rd_col}), 32'd0);
        chk("reset_cmd", 32'(reg_array_cmd), 32'(all_ne()));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_block("basic", 1, 1, 0, 0, 0, -1);
        run_block("stride2", 4, 2, 0, 0, 0, -1);
        run_block("stride0", 3, 0, 0, 0, 0, -1);
        run_block("stride3", 2, 3, 0, 0, 0, -1);
        run_block("ncol0", 0, 1, 0, 0, 0, -1);
        run_block("hold5", 2, 1, 0, 5, 5, -1);
        run_block("restart", 2, 2, 0, 0, 0, 6);
        run_block("start_hold", 1, 1, 3, 0, 0, -1);

        // Reset in the middle of a block, then a clean block.
        cfg_ncol = COL_W'(3);
        cfg_stride = 2'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_strobes", 32'({rd_en, fifo_read, dwpe_ena, busy, done}), 32'd0);
        chk("midrst_cmd", 32'({rd_rpsel, reg_array_cmd}), 32'({2'b11, all_ne()}));
        chk("midrst_addr", 32'({rd_bank, rd_row, rd_col}), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_block("after_rst", 2, 2, 0, 0, 0, -1);

        for (int r = 0; r < 6; r++) begin
            int nc, sc, ph, ha, hl;
            nc = $urandom_range(1, 5);
            sc = $urandom_range(0, 3);
            ph = $urandom_range(0, 2);
            hl = $urandom_range(0, 4);
            ha = $urandom_range(ph + RD_LAT + 1, ph + nc * KSIZE * KSIZE);
            run_block($sformatf("rnd%0d", r), nc, sc, ph, ha, hl, ph + 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
